ecall_halt_controller: RTL

- Consumer side of the ECALL-halt check in the 5-stage pipelined RV32I core.
- Resolves the x17 argument of an ECALL sitting in ID/EX, using forwarding priority EX/MEM, then MEM/WB, then register file.
- On a halt request it freezes fetch, squashes younger instructions and drains older ones plus the ECALL through WB, then raises a sticky is_halted.
- Sits beside the hazard detection unit; its stall and flush outputs are ORed into the pipeline-register controls.

---
 rtl/ecall_halt_controller_pkg.sv | 13 +
 rtl/ecall_halt_controller_arg_forward.sv | 27 ++
 rtl/ecall_halt_controller.sv | 75 +++++++
 3 files changed

// File: rtl/ecall_halt_controller_pkg.sv
// ecall_halt_controller_pkg: shared opcodes, FSM encoding and ECALL-halt defaults.
package ecall_halt_controller_pkg;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam int ARG_REG_DEF   = 17;
    localparam int HALT_CODE_DEF = 10;
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;
endpackage

// File: rtl/ecall_halt_controller_arg_forward.sv
// ecall_arg_forward: resolves the ECALL argument register with EX/MEM > MEM/WB > RF priority.
module ecall_arg_forward
    import ecall_halt_controller_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ARG_REG = ARG_REG_DEF
) (
    input  logic            ex_mem_reg_write,
    input  logic            ex_mem_mem_read,
    input  logic [4:0]      ex_mem_rd,
    input  logic [XLEN-1:0] ex_mem_alu_out,
    input  logic            mem_wb_reg_write,
    input  logic [4:0]      mem_wb_rd,
    input  logic [XLEN-1:0] mem_wb_wdata,
    input  logic [XLEN-1:0] rf_arg_data,
    output logic [XLEN-1:0] arg_value,
    output logic            arg_pending
);
    localparam logic [4:0] ARG = 5'(ARG_REG);
    logic ex_hit, wb_hit;
    always_comb begin
        ex_hit      = ex_mem_reg_write && ex_mem_rd == ARG;
        wb_hit      = mem_wb_reg_write && mem_wb_rd == ARG;
        arg_value   = ex_hit ? ex_mem_alu_out : wb_hit ? mem_wb_wdata : rf_arg_data;
        arg_pending = ex_hit && ex_mem_mem_read;
    end
endmodule

// File: rtl/ecall_halt_controller.sv
// ecall_halt_controller: detects a halting ECALL in ID/EX, drains older work, then halts stickily.
module ecall_halt_controller
    import ecall_halt_controller_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int ARG_REG      = ARG_REG_DEF,
    parameter int HALT_CODE    = HALT_CODE_DEF,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_ex_valid,
    input  logic            id_ex_is_ecall,
    input  logic            ex_mem_reg_write,
    input  logic            ex_mem_mem_read,
    input  logic [4:0]      ex_mem_rd,
    input  logic [XLEN-1:0] ex_mem_alu_out,
    input  logic            mem_wb_reg_write,
    input  logic [4:0]      mem_wb_rd,
    input  logic [XLEN-1:0] mem_wb_wdata,
    input  logic [XLEN-1:0] rf_arg_data,
    output logic            stall_front,
    output logic            flush_id_ex,
    output logic            flush_if_id,
    output logic            is_halted
);
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    state_t          state;
    logic [CW-1:0]   drain_cnt;
    logic [XLEN-1:0] arg_value;
    logic            arg_pending, ecall_seen, halt_req, run;

    ecall_arg_forward #(.XLEN(XLEN), .ARG_REG(ARG_REG)) u_fwd (
        .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_mem_read (ex_mem_mem_read),
        .ex_mem_rd       (ex_mem_rd),
        .ex_mem_alu_out  (ex_mem_alu_out),
        .mem_wb_reg_write(mem_wb_reg_write),
        .mem_wb_rd       (mem_wb_rd),
        .mem_wb_wdata    (mem_wb_wdata),
        .rf_arg_data     (rf_arg_data),
        .arg_value       (arg_value),
        .arg_pending     (arg_pending)
    );

    always_comb begin
        ecall_seen  = id_ex_valid && id_ex_is_ecall;
        halt_req    = ecall_seen && !arg_pending && arg_value == XLEN'(HALT_CODE);
        run         = state == RUN;
        // gated by reset so an ECALL held in ID/EX cannot leak through while in reset
        stall_front = !reset && (run ? ecall_seen && (arg_pending || halt_req) : 1'b1);
        flush_if_id = !reset && run && halt_req;
        flush_id_ex = !reset && !run;
        is_halted   = !reset && state == HALTED;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            case (state)
                RUN: if (halt_req) begin
                    state     <= DRAIN;
                    drain_cnt <= CW'(1);
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + CW'(1);
                    if (drain_cnt == CW'(DRAIN_CYCLES)) state <= HALTED;
                end
                default: state <= HALTED;
            endcase
        end
    end
endmodule
